pwm_deadtime: RTL

//  Complementary-output stage directly downstream of pwm_bus_interface. It consumes
//  the single-ended pwm signal and drives a half-bridge high-side/low-side pair
//  (pwm_h, pwm_l). It inserts a programmable dead time at every transition and

---
 rtl/pwm_deadtime.sv | 71 +++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary half-bridge drive with programmable dead time and latched fault trip
module pwm_deadtime #(
  parameter int DT_WIDTH = 16,
  parameter int SW_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm,
  input  logic                en,
  input  logic [DT_WIDTH-1:0] dead_time,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                fault_latched,
  output logic                dt_active,
  output logic [SW_WIDTH-1:0] swallow_cnt
);
  typedef enum logic [2:0] {OFF, DT_H, H_ON, DT_L, L_ON} state_t;
  state_t state;
  logic [DT_WIDTH-1:0] cnt;
  logic pwm_r;
  logic cnt_done;
  logic [SW_WIDTH-1:0] sw_next;
  assign cnt_done = cnt[DT_WIDTH-1:1] == '0;
  assign sw_next = swallow_cnt + SW_WIDTH'(swallow_cnt != '1);
  assign pwm_h = state == H_ON;
  assign pwm_l = state == L_ON;
  assign dt_active = state == DT_H || state == DT_L;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt <= '0;
      pwm_r <= 1'b0;
      fault_latched <= 1'b0;
      swallow_cnt <= '0;
    end else begin
      pwm_r <= pwm;
      fault_latched <= fault ? 1'b1 : fault_clr ? 1'b0 : fault_latched;
      if (fault || !en) state <= OFF;
      else case (state)
        OFF: if (!fault_latched) begin
          state <= pwm_r ? DT_H : DT_L;
          cnt <= dead_time;
        end
        // a reversal inside the dead interval restarts it toward the other side
        DT_H: if (!pwm_r) begin
          state <= DT_L;
          cnt <= dead_time;
          swallow_cnt <= sw_next;
        end else if (cnt_done) state <= H_ON;
        else cnt <= cnt - 1'b1;
        DT_L: if (pwm_r) begin
          state <= DT_H;
          cnt <= dead_time;
          swallow_cnt <= sw_next;
        end else if (cnt_done) state <= L_ON;
        else cnt <= cnt - 1'b1;
        H_ON: if (!pwm_r) begin
          state <= DT_L;
          cnt <= dead_time;
        end
        L_ON: if (pwm_r) begin
          state <= DT_H;
          cnt <= dead_time;
        end
        default: state <= OFF;
      endcase
    end
  end
endmodule
